// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural register file with per-register ROB rename tags and commit bypass.
module reg_rename_file #(
    parameter int XLEN  = 32,
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy_i,
    input  logic             flush_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    output logic             rs1_busy_o,
    output logic             rs2_busy_o,
    output logic [ROB_W-1:0] rs1_tag_o,
    output logic [ROB_W-1:0] rs2_tag_o,
    output logic [XLEN-1:0]  rs1_val_o,
    output logic [XLEN-1:0]  rs2_val_o,
    input  logic             upd_flag_i,
    input  logic [ROB_W-1:0] upd_idx_i,
    input  logic [4:0]       upd_rd_i,
    input  logic             write_flag_i,
    input  logic [ROB_W-1:0] write_idx_i,
    input  logic [4:0]       write_rd_i,
    input  logic [XLEN-1:0]  new_val_i,
    output logic [31:0]      commit_cnt_o
);
    typedef struct packed {
        logic             busy;
        logic [ROB_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } rd_t;

    logic [XLEN-1:0]  val_q [32];
    logic [ROB_W-1:0] tag_q [32];
    logic [31:0]      busy_q;
    logic [31:0]      cnt_q, cnt_d;
    logic             commit, rename;
    rd_t              p1, p2;

    assign commit = write_flag_i && !flush_i && write_rd_i != 5'd0;
    assign rename = upd_flag_i && !flush_i && upd_rd_i != 5'd0;
    assign cnt_d  = cnt_q + 32'd1;

    // A commit from the exact producer a source waits on resolves it in the same cycle.
    function automatic rd_t rd_port(input logic [4:0] rs);
        logic hit;
        rd_t  r;
        hit    = write_flag_i && !flush_i && write_rd_i == rs && write_idx_i == tag_q[rs];
        r.busy = rs != 5'd0 && busy_q[rs] && !hit;
        r.tag  = rs != 5'd0 ? tag_q[rs] : '0;
        r.val  = rs == 5'd0 ? '0 : hit ? new_val_i : val_q[rs];
        return r;
    endfunction

    always_comb begin
        p1 = rd_port(rs1_i);
        p2 = rd_port(rs2_i);
    end

    assign rs1_busy_o   = p1.busy;
    assign rs1_tag_o    = p1.tag;
    assign rs1_val_o    = p1.val;
    assign rs2_busy_o   = p2.busy;
    assign rs2_tag_o    = p2.tag;
    assign rs2_val_o    = p2.val;
    assign commit_cnt_o = cnt_q;

    // Rename is assigned after commit so it wins busy/tag on the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else if (rdy_i) begin
            if (flush_i) begin
                busy_q <= '0;
            end else begin
                if (commit) begin
                    val_q[write_rd_i] <= new_val_i;
                    if (tag_q[write_rd_i] == write_idx_i) busy_q[write_rd_i] <= 1'b0;
                    cnt_q <= cnt_d;
                end
                if (rename) begin
                    busy_q[upd_rd_i] <= 1'b1;
                    tag_q[upd_rd_i]  <= upd_idx_i;
                end
            end
        end
    end
endmodule
